// File: rtl/sim_stop_monitor.sv
// sim_stop_monitor: decides when the machine under test has stopped (stable state + quiet activity) or timed out
// ports in : clk, reset (sync, active-high), enable, clear (sync soft clear), pu_state, act, act_mask
// ports out: machine_is_stop, stop_pulse, timeout, idle_count, transition_count, cycle_count
module sim_stop_monitor #(
  parameter int STATE_W        = 3,
  parameter int N_ACT          = 2,
  parameter int CNT_W          = 8,
  parameter int IDLE_LIMIT     = 255,
  parameter int STICKY         = 0,
  parameter int TO_W           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [STATE_W-1:0] pu_state,
  input  logic [N_ACT-1:0]   act,
  input  logic [N_ACT-1:0]   act_mask,
  output logic               machine_is_stop,
  output logic               stop_pulse,
  output logic               timeout,
  output logic [CNT_W-1:0]   idle_count,
  output logic [CNT_W-1:0]   transition_count,
  output logic [TO_W-1:0]    cycle_count
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] STOP = 2'd1;
  localparam logic [1:0] TMO = 2'd2;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(IDLE_LIMIT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0] TLIM = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TMAX = {TO_W{1'b1}};
  logic [1:0] st, st_nxt;
  logic [STATE_W-1:0] last_state;
  logic primed, stop_cond, to_cond;
  always_comb begin
    stop_cond = (idle_count == LIM) && ((act & act_mask) == '0);
    to_cond = (TIMEOUT_CYCLES != 0) && (cycle_count >= TLIM);
    // STOP has priority over TIMEOUT when both conditions appear together in RUN
    st_nxt = st == RUN  ? (stop_cond ? STOP : to_cond ? TMO : RUN) :
             st == STOP ? ((STICKY != 0 || stop_cond) ? STOP : RUN) : TMO;
  end
  assign machine_is_stop = st == STOP;
  assign timeout = st == TMO;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st <= RUN;
      last_state <= '0;
      primed <= 1'b0;
      idle_count <= '0;
      transition_count <= '0;
      cycle_count <= '0;
      stop_pulse <= 1'b0;
    end else if (enable) begin
      st <= st_nxt;
      stop_pulse <= (st == RUN) && stop_cond;
      last_state <= pu_state;
      primed <= 1'b1;
      cycle_count <= cycle_count == TMAX ? cycle_count : cycle_count + 1'b1;
      // the first enabled cycle only captures a reference state
      if (primed) begin
        if (pu_state == last_state) begin
          idle_count <= idle_count == LIM ? idle_count : idle_count + 1'b1;
        end else begin
          idle_count <= '0;
          transition_count <= transition_count == CMAX ? transition_count : transition_count + 1'b1;
        end
      end
    end else begin
      stop_pulse <= 1'b0;
    end
  end
endmodule
